i2c_adc_responder: RTL and testbench

I2C target (responder) that emulates a PCF8591-style 4-channel ADC/DAC at a configurable 7-bit address. It watches an externally driven SCL/SDA pair, accepts a control byte and optional DAC bytes on writes, and returns channel samples supplied by the fabric on reads. It sits on the I2C bus opposite our I2C master, as a bench and loopback device for that master, and drives SDA only as an open-drain pull-low enable.

---
 rtl/i2c_adc_responder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_i2c_adc_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_adc_responder.sv
`timescale 1ns/1ps
// I2C target emulating a PCF8591-style 4-channel ADC/DAC at SLAVE_ADDR.
// Latency: 3 clk from a pin change to the state action (2 sync + 1 edge detect); sda_oe registered.
// Backpressure: none, no clock stretching; SDA is only ever pulled low (open-drain enable).
module i2c_adc_responder #(
   parameter logic [6:0] SLAVE_ADDR = 7'h48
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [31:0] adc_data,
   output logic [7:0]  ctrl_reg,
   output logic        ctrl_wr_stb,
   output logic [7:0]  dac_out,
   output logic        dac_wr_stb,
   output logic        rd_stb,
   output logic        busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_BYTE,
      ST_WR_ACK,
      ST_RD_BYTE,
      ST_RD_ACK
   } state_t;

   // synchronizer, previous-value and edge detection
   logic scl_meta_q, scl_sync_q, scl_prev_q;
   logic sda_meta_q, sda_sync_q, sda_prev_q;
   logic scl_rise, scl_fall, start_det, stop_det;

   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  rx_q, rx_d;
   logic [7:0]  tx_q, tx_d;
   logic        ack_on_q, ack_on_d;    // ACK slots: second phase pending; RD_ACK: master ACKed
   logic        rw_q, rw_d;
   logic        first_q, first_d;      // next written byte is the control byte
   logic        sda_oe_q, sda_oe_d;
   logic        busy_q, busy_d;
   logic [7:0]  ctrl_q, ctrl_d;
   logic [7:0]  dac_q, dac_d;
   logic        ctrl_stb_q, ctrl_stb_d;
   logic        dac_stb_q, dac_stb_d;
   logic        rd_stb_q, rd_stb_d;

   logic [7:0]  rx_byte;
   logic [7:0]  ld_byte;
   logic        do_load;

   // bring both bus lines into the clk domain and keep one cycle of history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_meta_q <= 1'b1;
         scl_sync_q <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_meta_q <= scl_in;
         scl_sync_q <= scl_meta_q;
         scl_prev_q <= scl_sync_q;
         sda_meta_q <= sda_in;
         sda_sync_q <= sda_meta_q;
         sda_prev_q <= sda_sync_q;
      end
   end

   assign scl_rise  = scl_sync_q & ~scl_prev_q;
   assign scl_fall  = ~scl_sync_q & scl_prev_q;
   assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
   assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

   // byte being completed by the current rising edge, and the channel sample to transmit
   assign rx_byte = {rx_q[6:0], sda_sync_q};
   assign ld_byte = adc_data[{ctrl_q[1:0], 3'b000} +: 8];

   // state register and all datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 4'd0;
         rx_q       <= 8'h00;
         tx_q       <= 8'h00;
         ack_on_q   <= 1'b0;
         rw_q       <= 1'b0;
         first_q    <= 1'b0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         ctrl_q     <= 8'h00;
         dac_q      <= 8'h00;
         ctrl_stb_q <= 1'b0;
         dac_stb_q  <= 1'b0;
         rd_stb_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         ack_on_q   <= ack_on_d;
         rw_q       <= rw_d;
         first_q    <= first_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         ctrl_q     <= ctrl_d;
         dac_q      <= dac_d;
         ctrl_stb_q <= ctrl_stb_d;
         dac_stb_q  <= dac_stb_d;
         rd_stb_q   <= rd_stb_d;
      end
   end

   // next-state and output decode; START/STOP override every state
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_d       = rx_q;
      tx_d       = tx_q;
      ack_on_d   = ack_on_q;
      rw_d       = rw_q;
      first_d    = first_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;
      ctrl_d     = ctrl_q;
      dac_d      = dac_q;
      ctrl_stb_d = 1'b0;
      dac_stb_d  = 1'b0;
      rd_stb_d   = 1'b0;
      do_load    = 1'b0;

      if (stop_det) begin
         state_d  = ST_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
         ack_on_d = 1'b0;
      end else if (start_det) begin
         state_d   = ST_ADDR;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
         ack_on_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sda_oe_d = 1'b0;
            end
            ST_ADDR: begin
               if (scl_rise) begin
                  rx_d = rx_byte;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = 4'd0;
                     if (rx_byte[7:1] == SLAVE_ADDR) begin
                        state_d  = ST_ADDR_ACK;
                        rw_d     = rx_byte[0];
                        first_d  = 1'b1;
                        busy_d   = 1'b1;
                        ack_on_d = 1'b0;
                     end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_ADDR_ACK, ST_WR_ACK: begin
               // first fall pulls SDA for the ACK bit, second fall ends the slot
               if (scl_fall) begin
                  if (!ack_on_q) begin
                     sda_oe_d = 1'b1;
                     ack_on_d = 1'b1;
                  end else begin
                     ack_on_d = 1'b0;
                     if (state_q == ST_WR_ACK || !rw_q) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WR_BYTE;
                     end else begin
                        do_load = 1'b1;
                     end
                  end
               end
            end
            ST_WR_BYTE: begin
               if (scl_rise) begin
                  rx_d = rx_byte;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = 4'd0;
                     ack_on_d  = 1'b0;
                     state_d   = ST_WR_ACK;
                     if (first_q) begin
                        ctrl_d     = rx_byte;
                        ctrl_stb_d = 1'b1;
                        first_d    = 1'b0;
                     end else begin
                        dac_d     = rx_byte;
                        dac_stb_d = 1'b1;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_RD_BYTE: begin
               // bit_cnt counts bits already placed on the bus
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     ack_on_d = 1'b0;
                     state_d  = ST_RD_ACK;
                  end else begin
                     sda_oe_d  = ~tx_q[6];
                     tx_d      = {tx_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_sync_q) begin
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                  end else begin
                     ack_on_d = 1'b1;
                  end
               end else if (scl_fall && ack_on_q) begin
                  ack_on_d = 1'b0;
                  do_load  = 1'b1;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               sda_oe_d = 1'b0;
               busy_d   = 1'b0;
            end
         endcase
      end

      // load the next read byte, drive its MSB and optionally advance the channel
      if (do_load) begin
         tx_d      = ld_byte;
         sda_oe_d  = ~ld_byte[7];
         bit_cnt_d = 4'd1;
         rd_stb_d  = 1'b1;
         state_d   = ST_RD_BYTE;
         if (ctrl_q[2]) begin
            ctrl_d[1:0] = ctrl_q[1:0] + 2'd1;
         end
      end
   end

   assign sda_oe      = sda_oe_q;
   assign busy        = busy_q;
   assign ctrl_reg    = ctrl_q;
   assign dac_out     = dac_q;
   assign ctrl_wr_stb = ctrl_stb_q;
   assign dac_wr_stb  = dac_stb_q;
   assign rd_stb      = rd_stb_q;

endmodule

// File: tb/tb_i2c_adc_responder.sv
`timescale 1ns/1ps
// Bench for i2c_adc_responder: a behavioural I2C master drives SCL/SDA,
// expected bytes are queued as stimulus is issued and compared as the DUT produces them.
module tb_i2c_adc_responder;

   localparam int Q = 100;   // quarter SCL period in ns (SCL = 2.5 MHz, clk = 100 MHz)

   logic        clk = 1'b0;
   logic        rst;
   logic        scl;
   logic        m_sda;
   logic        sda_line;
   logic        sda_oe;
   logic [31:0] adc_data;
   logic [7:0]  ctrl_reg;
   logic        ctrl_wr_stb;
   logic [7:0]  dac_out;
   logic        dac_wr_stb;
   logic        rd_stb;
   logic        busy;

   assign sda_line = m_sda & ~sda_oe;

   i2c_adc_responder #(.SLAVE_ADDR(7'h48)) dut (
      .clk        (clk),
      .rst        (rst),
      .scl_in     (scl),
      .sda_in     (sda_line),
      .sda_oe     (sda_oe),
      .adc_data   (adc_data),
      .ctrl_reg   (ctrl_reg),
      .ctrl_wr_stb(ctrl_wr_stb),
      .dac_out    (dac_out),
      .dac_wr_stb (dac_wr_stb),
      .rd_stb     (rd_stb),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_ctrl_q[$];
   logic [7:0] exp_dac_q[$];
   logic [7:0] exp_rd_q[$];
   int ctrl_stb_n = 0;
   int dac_stb_n  = 0;
   int rd_stb_n   = 0;
   bit oe_seen    = 1'b0;
   bit busy_seen  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // strobe monitor: counts high cycles (so a stretched strobe is visible) and scores written values
   always @(negedge clk) begin
      if (ctrl_wr_stb) begin
         ctrl_stb_n++;
         if (exp_ctrl_q.size() == 0) check("ctrl_unexpected", 1, 0);
         else check("ctrl_value", {24'h0, ctrl_reg}, {24'h0, exp_ctrl_q.pop_front()});
      end
      if (dac_wr_stb) begin
         dac_stb_n++;
         if (exp_dac_q.size() == 0) check("dac_unexpected", 1, 0);
         else check("dac_value", {24'h0, dac_out}, {24'h0, exp_dac_q.pop_front()});
      end
      if (rd_stb) rd_stb_n++;
      if (sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
   end

   task automatic bus_start;
      m_sda = 1'b1; #(Q);
      scl = 1'b1;   #(Q);
      m_sda = 1'b0; #(Q);
      scl = 1'b0;   #(Q);
   endtask

   task automatic bus_stop;
      m_sda = 1'b0; #(Q);
      scl = 1'b1;   #(Q);
      m_sda = 1'b1; #(Q);
   endtask

   task automatic send_bit(input logic b);
      m_sda = b; #(Q);
      scl = 1'b1; #(2*Q);
      scl = 1'b0; #(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic acked);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      m_sda = 1'b1; #(Q);
      scl = 1'b1;   #(Q);
      acked = ~sda_line;
      #(Q);
      scl = 1'b0;   #(Q);
   endtask

   // reads one byte, answers with ACK (nack=0) or NACK, and scores it against the queue
   task automatic read_byte(input logic nack, input string tag);
      logic [7:0] d;
      d = 8'h00;
      m_sda = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #(Q);
         scl = 1'b1; #(Q);
         d = {d[6:0], sda_line};
         #(Q);
         scl = 1'b0; #(Q);
      end
      m_sda = nack; #(Q);
      scl = 1'b1;   #(Q);
      if (nack) check({tag, "_nack_oe"}, {31'h0, sda_oe}, 0);
      #(Q);
      scl = 1'b0;   #(Q);
      m_sda = 1'b1;
      if (exp_rd_q.size() == 0) check({tag, "_unexpected"}, 1, 0);
      else check(tag, {24'h0, d}, {24'h0, exp_rd_q.pop_front()});
   endtask

   task automatic write_txn(input logic [7:0] addr, input logic [7:0] b0, input string tag);
      logic ack;
      bus_start;
      write_byte(addr, ack);
      check({tag, "_addr_ack"}, {31'h0, ack}, 1);
      write_byte(b0, ack);
      check({tag, "_data_ack"}, {31'h0, ack}, 1);
   endtask

   initial begin
      logic ack;
      int   c0;
      rst = 1'b1; scl = 1'b1; m_sda = 1'b1; adc_data = 32'h0;
      repeat (5) @(negedge clk);
      check("rst_oe",   {31'h0, sda_oe}, 0);
      check("rst_busy", {31'h0, busy}, 0);
      check("rst_ctrl", {24'h0, ctrl_reg}, 0);
      check("rst_dac",  {24'h0, dac_out}, 0);
      check("rst_stb",  {29'h0, ctrl_wr_stb, dac_wr_stb, rd_stb}, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // write control byte
      exp_ctrl_q.push_back(8'h03);
      write_txn(8'h90, 8'h03, "wr_ctrl");
      check("wr_busy_mid", {31'h0, busy}, 1);
      bus_stop;
      check("wr_ctrl_reg", {24'h0, ctrl_reg}, 32'h03);
      check("wr_ctrl_stbs", ctrl_stb_n, 1);
      check("wr_busy_after", {31'h0, busy}, 0);

      // single read from channel 3, master NACKs
      adc_data = 32'hA500_0000;
      exp_rd_q.push_back(8'hA5);
      bus_start;
      write_byte(8'h91, ack);
      check("rd1_addr_ack", {31'h0, ack}, 1);
      read_byte(1'b1, "rd1_byte");
      check("rd1_busy", {31'h0, busy}, 0);
      bus_stop;
      check("rd1_stbs", rd_stb_n, 1);

      // auto-increment from channel 2 across the wrap
      exp_ctrl_q.push_back(8'h06);
      write_txn(8'h90, 8'h06, "wr_ai");
      bus_stop;
      adc_data = 32'h4433_2211;
      exp_rd_q.push_back(8'h33);
      exp_rd_q.push_back(8'h44);
      exp_rd_q.push_back(8'h11);
      exp_rd_q.push_back(8'h22);
      bus_start;
      write_byte(8'h91, ack);
      check("ai_addr_ack", {31'h0, ack}, 1);
      for (int i = 0; i < 4; i++) read_byte(i == 3, "ai_byte");
      bus_stop;
      check("ai_chan", {30'h0, ctrl_reg[1:0]}, 2);
      check("ai_rd_stbs", rd_stb_n, 5);
      check("ai_ctrl_stbs", ctrl_stb_n, 2);

      // control byte followed by two DAC bytes
      exp_ctrl_q.push_back(8'h04);
      exp_dac_q.push_back(8'h7F);
      exp_dac_q.push_back(8'h80);
      write_txn(8'h90, 8'h04, "dac");
      write_byte(8'h7F, ack);
      check("dac_ack1", {31'h0, ack}, 1);
      write_byte(8'h80, ack);
      check("dac_ack2", {31'h0, ack}, 1);
      bus_stop;
      check("dac_out", {24'h0, dac_out}, 32'h80);
      check("dac_stbs", dac_stb_n, 2);
      check("dac_ctrl", {24'h0, ctrl_reg}, 32'h04);

      // abort: STOP after four bits of the control byte
      c0 = ctrl_stb_n;
      bus_start;
      write_byte(8'h90, ack);
      check("abort_addr_ack", {31'h0, ack}, 1);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      bus_stop;
      repeat (5) @(negedge clk);
      check("abort_ctrl", {24'h0, ctrl_reg}, 32'h04);
      check("abort_stbs", ctrl_stb_n, c0);
      check("abort_busy", {31'h0, busy}, 0);

      // address mismatch: bus stays untouched
      oe_seen = 1'b0;
      busy_seen = 1'b0;
      bus_start;
      write_byte(8'h92, ack);
      check("mis_addr_ack", {31'h0, ack}, 0);
      write_byte(8'h05, ack);
      check("mis_data_ack", {31'h0, ack}, 0);
      bus_stop;
      repeat (5) @(negedge clk);
      check("mis_oe_seen", {31'h0, oe_seen}, 0);
      check("mis_busy_seen", {31'h0, busy_seen}, 0);
      check("mis_ctrl", {24'h0, ctrl_reg}, 32'h04);

      // reset in the middle of a read of 0x00 (SDA held low by the DUT)
      adc_data = 32'h0;
      bus_start;
      write_byte(8'h91, ack);
      check("rst_rd_ack", {31'h0, ack}, 1);
      m_sda = 1'b1;
      #(Q); scl = 1'b1; #(2*Q); scl = 1'b0; #(2*Q);
      @(negedge clk); #1;
      check("rst_rd_oe_pre", {31'h0, sda_oe}, 1);
      rst = 1'b1;
      #1;
      check("rst_rd_oe_async", {31'h0, sda_oe}, 0);
      check("rst_rd_busy", {31'h0, busy}, 0);
      check("rst_rd_ctrl", {24'h0, ctrl_reg}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      bus_stop;
      repeat (5) @(negedge clk);

      check("q_ctrl_empty", exp_ctrl_q.size(), 0);
      check("q_dac_empty",  exp_dac_q.size(), 0);
      check("q_rd_empty",   exp_rd_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
